// File: rtl/dcache_miss_ctrl_if.sv
// Signal bundle between the DCache miss controller and its environment:
// load-pipeline miss port, DCache SRAM ports, and the memory-side burst bus.
interface dcache_miss_ctrl_if #(
    parameter int PALEN      = 32,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 8
);
    localparam int WAY_W = $clog2(WAYS);
    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam int TAG_W = PALEN - IDX_W - OFF_W;

    // load pipeline
    logic                    miss_valid;
    logic                    miss_ready;
    logic [PALEN-1:0]        miss_paddr;
    logic [WAY_W-1:0]        miss_way;
    logic                    victim_valid;
    logic                    victim_dirty;
    logic [PALEN-1:0]        victim_paddr;
    logic                    stall_o;
    logic                    done_o;
    logic [31:0]             done_data;

    // DCache SRAMs
    logic                    dram_rd_en;
    logic [WAY_W-1:0]        dram_rd_way;
    logic [IDX_W-1:0]        dram_rd_idx;
    logic [LINE_WORDS*32-1:0] dram_rd_line;
    logic                    dram_wr_en;
    logic [LINE_WORDS*32-1:0] dram_wr_line;
    logic                    tag_wr_en;
    logic [TAG_W-1:0]        tag_wr_tag;
    logic [WAY_W-1:0]        wr_way;
    logic [IDX_W-1:0]        wr_idx;

    // memory burst bus
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_req_write;
    logic [PALEN-1:0]        mem_req_addr;
    logic                    mem_wdata_valid;
    logic                    mem_wdata_ready;
    logic [31:0]             mem_wdata;
    logic                    mem_wdata_last;
    logic                    mem_wresp_valid;
    logic                    mem_rdata_valid;
    logic [31:0]             mem_rdata;
    logic                    mem_rdata_last;

    modport master (
        input  miss_valid, miss_paddr, miss_way, victim_valid, victim_dirty, victim_paddr,
        input  dram_rd_line, mem_req_ready, mem_wdata_ready, mem_wresp_valid,
        input  mem_rdata_valid, mem_rdata, mem_rdata_last,
        output miss_ready, stall_o, done_o, done_data,
        output dram_rd_en, dram_rd_way, dram_rd_idx, dram_wr_en, dram_wr_line,
        output tag_wr_en, tag_wr_tag, wr_way, wr_idx,
        output mem_req_valid, mem_req_write, mem_req_addr,
        output mem_wdata_valid, mem_wdata, mem_wdata_last
    );

    modport slave (
        output miss_valid, miss_paddr, miss_way, victim_valid, victim_dirty, victim_paddr,
        output dram_rd_line, mem_req_ready, mem_wdata_ready, mem_wresp_valid,
        output mem_rdata_valid, mem_rdata, mem_rdata_last,
        input  miss_ready, stall_o, done_o, done_data,
        input  dram_rd_en, dram_rd_way, dram_rd_idx, dram_wr_en, dram_wr_line,
        input  tag_wr_en, tag_wr_tag, wr_way, wr_idx,
        input  mem_req_valid, mem_req_write, mem_req_addr,
        input  mem_wdata_valid, mem_wdata, mem_wdata_last
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Single-entry DCache miss handler: optional dirty-victim writeback, then line
// refill, then one-cycle tag/data commit with the requested word for replay.
module dcache_miss_ctrl #(
    parameter int PALEN      = 32,
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 8
) (
    input  logic            clk,
    input  logic            a_rst,
    dcache_miss_ctrl_if.master bus
);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = PALEN - OFF_W;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_WB_READ = 4'd1;
    localparam logic [3:0] S_WB_CAP  = 4'd2;
    localparam logic [3:0] S_WB_REQ  = 4'd3;
    localparam logic [3:0] S_WB_DATA = 4'd4;
    localparam logic [3:0] S_WB_RESP = 4'd5;
    localparam logic [3:0] S_RF_REQ  = 4'd6;
    localparam logic [3:0] S_RF_DATA = 4'd7;
    localparam logic [3:0] S_COMMIT  = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINE_W-1:0]  r_line;
    logic [LINE_W-1:0]  r_vic_line;
    logic [CNT_W-1:0]   r_word;
    logic [WAY_W-1:0]   r_way;
    logic [31:0]        r_buf [LINE_WORDS];

    logic               w_accept;
    logic               w_wb_start;
    logic               w_rf_start;
    logic               w_wbeat;
    logic               w_rbeat;
    logic               w_cnt_last;
    logic               w_commit;
    logic [LINE_WORDS*32-1:0] w_line_flat;
    logic               w_unused;

    assign w_accept   = (r_state == S_IDLE) && bus.miss_valid;
    assign w_wb_start = (r_state == S_WB_REQ) && bus.mem_req_ready;
    assign w_rf_start = (r_state == S_RF_REQ) && bus.mem_req_ready;
    assign w_wbeat    = (r_state == S_WB_DATA) && bus.mem_wdata_ready;
    assign w_rbeat    = (r_state == S_RF_DATA) && bus.mem_rdata_valid;
    assign w_cnt_last = (r_cnt == CNT_W'(LINE_WORDS - 1));
    assign w_commit   = (r_state == S_COMMIT);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.miss_valid) begin
                    w_state_next = (bus.victim_valid && bus.victim_dirty) ? S_WB_READ : S_RF_REQ;
                end
            end
            S_WB_READ: w_state_next = S_WB_CAP;
            S_WB_CAP:  w_state_next = S_WB_REQ;
            S_WB_REQ:  if (bus.mem_req_ready) w_state_next = S_WB_DATA;
            S_WB_DATA: if (w_wbeat && w_cnt_last) w_state_next = S_WB_RESP;
            S_WB_RESP: if (bus.mem_wresp_valid) w_state_next = S_RF_REQ;
            S_RF_REQ:  if (bus.mem_req_ready) w_state_next = S_RF_DATA;
            S_RF_DATA: if (w_rbeat && (bus.mem_rdata_last || w_cnt_last)) w_state_next = S_COMMIT;
            S_COMMIT:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_line     <= '0;
            r_vic_line <= '0;
            r_word     <= '0;
            r_way      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_line     <= bus.miss_paddr[PALEN-1:OFF_W];
                r_word     <= bus.miss_paddr[OFF_W-1:2];
                r_way      <= bus.miss_way;
                r_vic_line <= bus.victim_paddr[PALEN-1:OFF_W];
            end
            if (w_wb_start || w_rf_start) begin
                r_cnt <= '0;
            end else if (w_wbeat || w_rbeat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // The buffer holds the victim during writeback, then is zeroed at refill
    // start so words missing after an early last beat commit as zero.
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_buf
            always_ff @(posedge clk or posedge a_rst) begin
                if (a_rst) begin
                    r_buf[gi] <= '0;
                end else if (w_rf_start) begin
                    r_buf[gi] <= '0;
                end else if (r_state == S_WB_CAP) begin
                    r_buf[gi] <= bus.dram_rd_line[gi*32 +: 32];
                end else if (w_rbeat && (r_cnt == CNT_W'(gi))) begin
                    r_buf[gi] <= bus.mem_rdata;
                end
            end
            assign w_line_flat[gi*32 +: 32] = r_buf[gi];
        end
    endgenerate

    assign bus.miss_ready = (r_state == S_IDLE);
    assign bus.stall_o    = (r_state != S_IDLE);

    assign bus.dram_rd_en  = (r_state == S_WB_READ);
    assign bus.dram_rd_way = (r_state == S_WB_READ) ? r_way : '0;
    assign bus.dram_rd_idx = (r_state == S_WB_READ) ? r_vic_line[IDX_W-1:0] : '0;

    assign bus.dram_wr_en   = w_commit;
    assign bus.dram_wr_line = w_commit ? w_line_flat : '0;
    assign bus.tag_wr_en    = w_commit;
    assign bus.tag_wr_tag   = w_commit ? r_line[LINE_W-1:IDX_W] : '0;
    assign bus.wr_way       = w_commit ? r_way : '0;
    assign bus.wr_idx       = w_commit ? r_line[IDX_W-1:0] : '0;

    // Request fields come only from latched state, so they hold while waiting.
    assign bus.mem_req_valid = (r_state == S_WB_REQ) || (r_state == S_RF_REQ);
    assign bus.mem_req_write = (r_state == S_WB_REQ);
    assign bus.mem_req_addr  = (r_state == S_WB_REQ) ? {r_vic_line, {OFF_W{1'b0}}} :
                               (r_state == S_RF_REQ) ? {r_line, {OFF_W{1'b0}}} : '0;

    assign bus.mem_wdata_valid = (r_state == S_WB_DATA);
    assign bus.mem_wdata       = (r_state == S_WB_DATA) ? r_buf[r_cnt] : '0;
    assign bus.mem_wdata_last  = (r_state == S_WB_DATA) && w_cnt_last;

    assign bus.done_o    = w_commit;
    assign bus.done_data = w_commit ? r_buf[r_word] : '0;

    assign w_unused = ^{bus.miss_paddr[1:0], bus.victim_paddr[OFF_W-1:0]};
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: a small bus responder plus hand-computed
// expectations for clean, dirty, backpressured, overlapped, reset and early-last misses.
module tb_dcache_miss_ctrl;
    localparam int PALEN = 32, WAYS = 2, LINE_WORDS = 4, IDX_W = 8;

    logic clk = 1'b0;
    logic a_rst;
    always #5 clk = ~clk;

    dcache_miss_ctrl_if #(.PALEN(PALEN), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W)) bus();

    dcache_miss_ctrl #(.PALEN(PALEN), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder configuration (written by the stimulus process only)
    int          req_wait_cfg = 0;
    bit          wtog_cfg     = 0;
    int          nbeats_cfg   = 4;
    logic [31:0] rwords [4];

    // responder statistics (written by the responder only)
    int          rd_req_cnt = 0, wr_req_cnt = 0, rd_en_cnt = 0, wbeat_cnt = 0;
    int          unstable_cnt = 0, order_err = 0;
    logic [31:0] rd_req_addr = '0, wr_req_addr = '0;
    logic [7:0]  rd_idx = '0;
    logic [31:0] wbeat [64];
    logic        wlast [64];

    int          req_wait = 0, rbeat = 0;
    bit          req_seen = 0, rd_active = 0, wresp_pend = 0, wb_busy = 0, wvalid_prev = 0;
    logic [31:0] held_addr = '0, wdata_prev = '0;
    logic        held_write = 1'b0;

    // Memory/SRAM model: samples DUT outputs at negedge, drives inputs for the next posedge.
    always @(negedge clk) begin
        if (a_rst) begin
            bus.mem_req_ready = 0; bus.mem_wdata_ready = 0; bus.mem_wresp_valid = 0;
            bus.mem_rdata_valid = 0; bus.mem_rdata_last = 0; bus.mem_rdata = '0;
            req_seen = 0; rd_active = 0; rbeat = 0; wresp_pend = 0; wb_busy = 0; wvalid_prev = 0;
        end else begin
            if (rd_active) begin
                if (rbeat < nbeats_cfg) begin
                    bus.mem_rdata_valid = 1; bus.mem_rdata = rwords[rbeat];
                    bus.mem_rdata_last = (rbeat == nbeats_cfg - 1);
                    rbeat++;
                end else begin
                    bus.mem_rdata_valid = 0; bus.mem_rdata_last = 0; bus.mem_rdata = '0;
                    rd_active = 0;
                end
            end
            bus.mem_wresp_valid = 0;
            if (wresp_pend) begin
                bus.mem_wresp_valid = 1; wresp_pend = 0; wb_busy = 0;
            end
            if (bus.mem_wdata_valid) begin
                if (wvalid_prev && bus.mem_wdata !== wdata_prev) unstable_cnt++;
                bus.mem_wdata_ready = wtog_cfg ? ~bus.mem_wdata_ready : 1'b1;
                if (bus.mem_wdata_ready) begin
                    wbeat[wbeat_cnt] = bus.mem_wdata; wlast[wbeat_cnt] = bus.mem_wdata_last;
                    wbeat_cnt++; wvalid_prev = 0;
                    if (bus.mem_wdata_last) wresp_pend = 1;
                end else begin
                    wvalid_prev = 1; wdata_prev = bus.mem_wdata;
                end
            end else begin
                bus.mem_wdata_ready = 0; wvalid_prev = 0;
            end
            if (bus.mem_req_valid) begin
                if (!req_seen) begin
                    req_seen = 1; req_wait = req_wait_cfg;
                    held_addr = bus.mem_req_addr; held_write = bus.mem_req_write;
                end else if (bus.mem_req_addr !== held_addr || bus.mem_req_write !== held_write) begin
                    unstable_cnt++;
                end
                if (req_wait > 0) begin
                    bus.mem_req_ready = 0; req_wait--;
                end else begin
                    bus.mem_req_ready = 1; req_seen = 0;
                    if (bus.mem_req_write) begin
                        wr_req_cnt++; wr_req_addr = bus.mem_req_addr; wb_busy = 1;
                    end else begin
                        rd_req_cnt++; rd_req_addr = bus.mem_req_addr;
                        if (wb_busy) order_err++;
                        rd_active = 1; rbeat = 0;
                    end
                end
            end else begin
                bus.mem_req_ready = 0;
            end
            if (bus.dram_rd_en) begin
                rd_en_cnt++; rd_idx = bus.dram_rd_idx;
            end
        end
    end

    // values captured at done_o
    logic [31:0]  d_data;
    logic [127:0] d_line;
    logic         d_way, d_tagwr, d_wren;
    logic [7:0]   d_idx;
    logic [19:0]  d_tag;
    int           d_lat, d_stall_lo;
    logic [2:0]   d_post;

    task automatic wait_done(input int acc);
        bit seen = 0;
        d_stall_lo = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (bus.done_o) begin
                seen = 1;
                d_data = bus.done_data; d_line = bus.dram_wr_line; d_way = bus.wr_way;
                d_idx = bus.wr_idx; d_tag = bus.tag_wr_tag; d_tagwr = bus.tag_wr_en;
                d_wren = bus.dram_wr_en; d_lat = cyc - acc;
            end else begin
                if (!bus.stall_o) d_stall_lo++;
                @(negedge clk);
            end
        end
        chk("done_seen", seen, 1);
        $display("miss done: lat=%0d data=%h line=%h way=%0d idx=%h tag=%h", d_lat, d_data, d_line, d_way, d_idx, d_tag);
    endtask

    task automatic do_miss(input logic [31:0] pa, input logic w, input logic vv, input logic vd,
                           input logic [31:0] vpa);
        int acc;
        @(negedge clk);
        bus.miss_paddr = pa; bus.miss_way = w; bus.victim_valid = vv;
        bus.victim_dirty = vd; bus.victim_paddr = vpa; bus.miss_valid = 1;
        chk("accept_ready", bus.miss_ready, 1);
        acc = cyc;
        @(negedge clk);
        bus.miss_valid = 0;
        wait_done(acc);
        @(negedge clk);
        d_post = {bus.done_o, bus.stall_o, bus.miss_ready};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, wb0, en0, un0, acc;
        logic [127:0] dline, wline;
        logic [3:0]   lbits;
        bit           busy_rdy;

        a_rst = 1;
        bus.miss_valid = 0; bus.miss_paddr = '0; bus.miss_way = '0;
        bus.victim_valid = 0; bus.victim_dirty = 0; bus.victim_paddr = '0;
        dline = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        bus.dram_rd_line = dline;
        repeat (2) @(negedge clk);
        chk("rst_miss_ready", bus.miss_ready, 1);
        chk("rst_stall", bus.stall_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_req_valid", bus.mem_req_valid, 0);
        chk("rst_dram_wr", bus.dram_wr_en, 0);
        a_rst = 0;

        // clean miss
        rwords[0] = 32'hA0; rwords[1] = 32'hA1; rwords[2] = 32'hA2; rwords[3] = 32'hA3;
        rd0 = rd_req_cnt; wr0 = wr_req_cnt;
        do_miss(32'h0000_1238, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("clean_lat", d_lat, 6);
        chk("clean_data", d_data, 32'hA2);
        chk("clean_line", d_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        chk("clean_way", d_way, 1);
        chk("clean_idx", d_idx, 8'h23);
        chk("clean_tag", d_tag, 20'h1);
        chk("clean_wr_en", {d_tagwr, d_wren}, 2'b11);
        chk("clean_rd_reqs", rd_req_cnt - rd0, 1);
        chk("clean_wr_reqs", wr_req_cnt - wr0, 0);
        chk("clean_rd_addr", rd_req_addr, 32'h0000_1230);
        chk("clean_post", d_post, 3'b001);

        // dirty victim
        rwords[0] = 32'hB0; rwords[1] = 32'hB1; rwords[2] = 32'hB2; rwords[3] = 32'hB3;
        wb0 = wbeat_cnt; en0 = rd_en_cnt; wr0 = wr_req_cnt;
        do_miss(32'h0000_9234, 1'b0, 1'b1, 1'b1, 32'h0000_5230);
        wline = {wbeat[wb0+3], wbeat[wb0+2], wbeat[wb0+1], wbeat[wb0]};
        lbits = {wlast[wb0+3], wlast[wb0+2], wlast[wb0+1], wlast[wb0]};
        chk("dirty_rd_en", rd_en_cnt - en0, 1);
        chk("dirty_rd_idx", rd_idx, 8'h23);
        chk("dirty_wr_reqs", wr_req_cnt - wr0, 1);
        chk("dirty_wr_addr", wr_req_addr, 32'h0000_5230);
        chk("dirty_beats", wbeat_cnt - wb0, 4);
        chk("dirty_wdata", wline, dline);
        chk("dirty_last", lbits, 4'b1000);
        chk("dirty_order", order_err, 0);
        chk("dirty_rd_addr", rd_req_addr, 32'h0000_9230);
        chk("dirty_data", d_data, 32'hB1);
        chk("dirty_line", d_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        chk("dirty_tag", d_tag, 20'h9);
        chk("dirty_lat", d_lat, 14);

        // backpressure on both request and write-data channels
        rwords[0] = 32'hF0; rwords[1] = 32'hF1; rwords[2] = 32'hF2; rwords[3] = 32'hF3;
        req_wait_cfg = 5; wtog_cfg = 1;
        wb0 = wbeat_cnt; un0 = unstable_cnt;
        do_miss(32'h0000_7238, 1'b1, 1'b1, 1'b1, 32'h0000_5230);
        wline = {wbeat[wb0+3], wbeat[wb0+2], wbeat[wb0+1], wbeat[wb0]};
        chk("bp_stable", unstable_cnt - un0, 0);
        chk("bp_beats", wbeat_cnt - wb0, 4);
        chk("bp_wdata", wline, dline);
        chk("bp_stall", d_stall_lo, 0);
        chk("bp_slowed", d_lat > 14, 1);
        chk("bp_order", order_err, 0);
        chk("bp_data", d_data, 32'hF2);
        chk("bp_rd_addr", rd_req_addr, 32'h0000_7230);
        req_wait_cfg = 0; wtog_cfg = 0;

        // second request held during a busy refill
        rwords[0] = 32'hA0; rwords[1] = 32'hA1; rwords[2] = 32'hA2; rwords[3] = 32'hA3;
        @(negedge clk);
        bus.miss_paddr = 32'h0000_1238; bus.miss_way = 1'b1;
        bus.victim_valid = 0; bus.victim_dirty = 0; bus.miss_valid = 1;
        acc = cyc;
        @(negedge clk);
        bus.miss_paddr = 32'h0000_2234; bus.miss_way = 1'b0;
        busy_rdy = 0;
        for (int i = 0; i < 50 && !bus.done_o; i++) begin
            if (bus.miss_ready) busy_rdy = 1;
            @(negedge clk);
        end
        chk("ovl_busy_ready", busy_rdy, 0);
        wait_done(acc);
        chk("ovl_ready_at_done", bus.miss_ready, 0);
        chk("ovl_first_data", d_data, 32'hA2);
        chk("ovl_first_tag", d_tag, 20'h1);
        @(negedge clk);
        chk("ovl_ready_after", bus.miss_ready, 1);
        acc = cyc;
        @(negedge clk);
        bus.miss_valid = 0;
        wait_done(acc);
        chk("ovl_second_data", d_data, 32'hA1);
        chk("ovl_second_tag", d_tag, 20'h2);
        chk("ovl_second_way", d_way, 0);
        chk("ovl_second_addr", rd_req_addr, 32'h0000_2230);
        chk("ovl_second_lat", d_lat, 6);

        // asynchronous reset during writeback data phase
        wtog_cfg = 1; wb0 = wbeat_cnt;
        @(negedge clk);
        bus.miss_paddr = 32'h0000_3238; bus.miss_way = 1'b0;
        bus.victim_valid = 1; bus.victim_dirty = 1; bus.victim_paddr = 32'h0000_5230;
        bus.miss_valid = 1;
        @(negedge clk);
        bus.miss_valid = 0;
        for (int i = 0; i < 100 && (wbeat_cnt - wb0) < 2; i++) @(negedge clk);
        chk("rst_mid_wb_reached", (wbeat_cnt - wb0) >= 2, 1);
        a_rst = 1;
        #1;
        chk("arst_ready", bus.miss_ready, 1);
        chk("arst_stall", bus.stall_o, 0);
        chk("arst_wvalid", bus.mem_wdata_valid, 0);
        chk("arst_wdata", bus.mem_wdata, 32'h0);
        chk("arst_req", bus.mem_req_valid, 0);
        @(negedge clk);
        a_rst = 0; wtog_cfg = 0;
        do_miss(32'h0000_3238, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("arst_after_lat", d_lat, 6);
        chk("arst_after_data", d_data, 32'hA2);
        chk("arst_after_tag", d_tag, 20'h3);

        // early last on beat 2
        rwords[0] = 32'hC0; rwords[1] = 32'hC1; rwords[2] = 32'hC2; rwords[3] = 32'hC3;
        nbeats_cfg = 3;
        do_miss(32'h0000_423C, 1'b1, 1'b1, 1'b0, 32'h0000_8230);
        chk("early_line", d_line, {32'h0, 32'hC2, 32'hC1, 32'hC0});
        chk("early_data", d_data, 32'h0);
        chk("early_lat", d_lat, 5);
        chk("early_post", d_post, 3'b001);
        nbeats_cfg = 4;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
